// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared pipeline-slot record, forward-select encodings and the
//           producer-match helper used by the hazard controller.
// Revision: 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Slot register addresses are stored at this fixed width; narrower
  // architectural addresses are zero-extended into it.
  localparam int SLOT_AW = 8;

  // Operand source select for the instruction currently in EX.
  localparam logic [1:0] FWD_ID    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               wr;
    logic               load;
  } slot_t;

  localparam slot_t SLOT_NONE = '0;

  // A slot produces r only if it is a live register write to a nonzero address.
  function automatic logic produces(input slot_t s, input logic [SLOT_AW-1:0] r);
    return s.valid && s.wr && (s.rd == r) && (r != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : pipe_scoreboard
// Brief   : Three-deep EX/MEM/WB slot shift register with bubble insertion
//           into EX and jump kill of the MEM slot.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_scoreboard
  import pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  issue,
  input  slot_t issue_slot,
  input  logic  kill,
  output slot_t s0,
  output slot_t s1,
  output slot_t s2
);

  slot_t r_s0, r_s1, r_s2;

  // Advance the slots every edge; a non-issue cycle becomes a bubble in EX and
  // a redirecting jump squashes whatever moves from EX into MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0 <= SLOT_NONE;
      r_s1 <= SLOT_NONE;
      r_s2 <= SLOT_NONE;
    end else begin
      r_s0 <= issue ? issue_slot : SLOT_NONE;
      r_s1 <= kill  ? SLOT_NONE  : r_s0;
      r_s2 <= r_s1;
    end
  end

  assign s0 = r_s0;
  assign s1 = r_s1;
  assign s2 = r_s2;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Decode-stage hazard detection, forward select generation, jump
//           flush control and saturating stall/flush performance counters.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 0,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              jump_taken,
  input  logic              cnt_clr,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam bit FWD   = (FWD_EN != 0);
  localparam bit NOBYP = (RF_BYPASS == 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SLOT_AW-1:0] w_rs1, w_rs2;
  logic               w_live1, w_live2, w_haz1, w_haz2, w_issue;
  slot_t              w_issue_slot, w_s0, w_s1, w_s2;
  logic [1:0]         w_sel_a, w_sel_b, r_fwd_a, r_fwd_b;
  logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;
  logic               w_unused;

  // With forwarding only a load in EX (data not ready) or a write-back the
  // register file cannot bypass blocks issue; without it every in-flight
  // producer does.
  function automatic logic src_hazard(input logic live, input logic [SLOT_AW-1:0] r,
                                      input slot_t s0, input slot_t s1, input slot_t s2);
    logic h;
    if (FWD) h = (produces(s0, r) && s0.load) || (NOBYP && produces(s2, r));
    else     h = produces(s0, r) || produces(s1, r) || (NOBYP && produces(s2, r));
    return live && h;
  endfunction

  // The youngest producer wins: EX/MEM result before MEM/WB write data.
  function automatic logic [1:0] fwd_pick(input logic live, input logic [SLOT_AW-1:0] r,
                                          input slot_t s0, input slot_t s1);
    logic [1:0] sel;
    sel = FWD_ID;
    if (live) begin
      if (produces(s0, r) && !s0.load) sel = FWD_EXMEM;
      else if (produces(s1, r))        sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  assign w_rs1   = SLOT_AW'(id_rs1);
  assign w_rs2   = SLOT_AW'(id_rs2);
  assign w_live1 = id_valid && id_rs1_used && (id_rs1 != '0);
  assign w_live2 = id_valid && id_rs2_used && (id_rs2 != '0);

  assign w_issue_slot.valid = 1'b1;
  assign w_issue_slot.rd    = SLOT_AW'(id_rd);
  assign w_issue_slot.wr    = id_reg_write;
  assign w_issue_slot.load  = id_is_load;

  // Hazard compare, stall/flush decision and next forward selects.
  always_comb begin
    w_haz1  = src_hazard(w_live1, w_rs1, w_s0, w_s1, w_s2);
    w_haz2  = src_hazard(w_live2, w_rs2, w_s0, w_s1, w_s2);
    stall   = id_valid && !jump_taken && (w_haz1 || w_haz2);
    w_issue = id_valid && !jump_taken && !(w_haz1 || w_haz2);
    w_sel_a = FWD_ID;
    w_sel_b = FWD_ID;
    if (FWD && w_issue) begin
      w_sel_a = fwd_pick(w_live1, w_rs1, w_s0, w_s1);
      w_sel_b = fwd_pick(w_live2, w_rs2, w_s0, w_s1);
    end
  end

  assign flush_if_id  = jump_taken;
  assign flush_id_ex  = jump_taken;
  assign flush_ex_mem = jump_taken;

  pipe_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue      (w_issue),
    .issue_slot (w_issue_slot),
    .kill       (jump_taken),
    .s0         (w_s0),
    .s1         (w_s1),
    .s2         (w_s2)
  );

  // Forward selects follow the instruction into EX; a bubble clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_a <= FWD_ID;
      r_fwd_b <= FWD_ID;
    end else begin
      r_fwd_a <= w_sel_a;
      r_fwd_b <= w_sel_b;
    end
  end

  // Saturating event counters; a clear request beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall && (r_stall_cnt != '1))      r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (jump_taken && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Load flags of MEM and WB never influence hazards or forwarding.
  assign w_unused = ^{w_s1.load, w_s2.load};

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Self-checking bench for hazard_ctrl: a forwarding instance and a
//           stall-only instance with a narrow counter, checked from a queue of
//           expected per-cycle outputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int X = -1;  // don't-care marker in an expectation

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ins_t;

  typedef struct {
    int    d;
    string tag;
    int    stl, fl, fa, fb, sc, fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // ---------------- instance A: forwarding, no RF bypass ----------------
  logic        rst_a;
  ins_t        in_a;
  logic        jmp_a, clr_a;
  logic        a_stall, a_f1, a_f2, a_f3;
  logic [1:0]  a_fa, a_fb;
  logic [31:0] a_sc, a_fc;

  hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .RF_BYPASS(0), .CNT_W(32)) u_fwd (
    .clk(clk), .rst(rst_a),
    .id_valid(in_a.v), .id_rs1(in_a.rs1), .id_rs2(in_a.rs2),
    .id_rs1_used(in_a.u1), .id_rs2_used(in_a.u2), .id_rd(in_a.rd),
    .id_reg_write(in_a.wr), .id_is_load(in_a.ld),
    .jump_taken(jmp_a), .cnt_clr(clr_a),
    .stall(a_stall), .flush_if_id(a_f1), .flush_id_ex(a_f2), .flush_ex_mem(a_f3),
    .fwd_a_sel(a_fa), .fwd_b_sel(a_fb), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  // ---------------- instance B: stall-only, 4-bit counters ----------------
  logic        rst_b;
  ins_t        in_b;
  logic        jmp_b, clr_b;
  logic        b_stall, b_f1, b_f2, b_f3;
  logic [1:0]  b_fa, b_fb;
  logic [3:0]  b_sc, b_fc;

  hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .RF_BYPASS(0), .CNT_W(4)) u_stl (
    .clk(clk), .rst(rst_b),
    .id_valid(in_b.v), .id_rs1(in_b.rs1), .id_rs2(in_b.rs2),
    .id_rs1_used(in_b.u1), .id_rs2_used(in_b.u2), .id_rd(in_b.rd),
    .id_reg_write(in_b.wr), .id_is_load(in_b.ld),
    .jump_taken(jmp_b), .cnt_clr(clr_b),
    .stall(b_stall), .flush_if_id(b_f1), .flush_id_ex(b_f2), .flush_ex_mem(b_f3),
    .fwd_a_sel(b_fa), .fwd_b_sel(b_fb), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic ins_t alu(input int rd, input int rs1, input int rs2);
    ins_t i;
    i = '0;
    i.v = 1'b1; i.u1 = 1'b1; i.u2 = 1'b1; i.wr = 1'b1;
    i.rd = rd[4:0]; i.rs1 = rs1[4:0]; i.rs2 = rs2[4:0];
    return i;
  endfunction

  function automatic ins_t lw(input int rd, input int rs1);
    ins_t i;
    i = '0;
    i.v = 1'b1; i.u1 = 1'b1; i.wr = 1'b1; i.ld = 1'b1;
    i.rd = rd[4:0]; i.rs1 = rs1[4:0];
    return i;
  endfunction

  localparam ins_t NOP = '0;

  // Drive one decode cycle just after the rising edge and queue the outputs
  // expected during that cycle.
  task automatic step(input int d, input string tag, input ins_t ins, input logic jmp,
                      input logic clr, input int stl, input int fa, input int fb,
                      input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    if (d == 0) begin in_a = ins; jmp_a = jmp; clr_a = clr; end
    else        begin in_b = ins; jmp_b = jmp; clr_b = clr; end
    e.d = d; e.tag = tag; e.stl = stl; e.fl = jmp ? 1 : 0;
    e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  // Compare queued expectations against the DUT mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.d == 0) begin
        if (e.stl >= 0) check({e.tag, "_stall"}, 32'(a_stall), e.stl);
        check({e.tag, "_flush"}, 32'({a_f1, a_f2, a_f3}), e.fl ? 7 : 0);
        if (e.fa >= 0) check({e.tag, "_fwd_a"}, 32'(a_fa), e.fa);
        if (e.fb >= 0) check({e.tag, "_fwd_b"}, 32'(a_fb), e.fb);
        if (e.sc >= 0) check({e.tag, "_stall_cnt"}, a_sc, e.sc);
        if (e.fc >= 0) check({e.tag, "_flush_cnt"}, a_fc, e.fc);
      end else begin
        if (e.stl >= 0) check({e.tag, "_stall"}, 32'(b_stall), e.stl);
        check({e.tag, "_flush"}, 32'({b_f1, b_f2, b_f3}), e.fl ? 7 : 0);
        if (e.fa >= 0) check({e.tag, "_fwd_a"}, 32'(b_fa), e.fa);
        if (e.fb >= 0) check({e.tag, "_fwd_b"}, 32'(b_fb), e.fb);
        if (e.sc >= 0) check({e.tag, "_stall_cnt"}, 32'(b_sc), e.sc);
        if (e.fc >= 0) check({e.tag, "_flush_cnt"}, 32'(b_fc), e.fc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    in_a = NOP; jmp_a = 1'b0; clr_a = 1'b0;
    in_b = NOP; jmp_b = 1'b0; clr_b = 1'b0;

    // Reset state, with a consumer presented to show stall stays low.
    step(0, "rst_a", alu(8, 1, 7), 0, 0, 0, 0, 0, 0, 0);
    step(1, "rst_b", alu(8, 1, 7), 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    in_a = NOP; in_b = NOP;

    // EX-to-EX forwarding: ADD x5 then SUB reading x5.
    step(0, "fwd_add", alu(5, 1, 2), 0, 0, 0, 0, 0, 0, 0);
    step(0, "fwd_sub", alu(6, 5, 2), 0, 0, 0, 0, 0, X, X);
    step(0, "fwd_ex",  NOP,          0, 0, 0, 1, 0, X, X);
    step(0, "fwd_bub", NOP,          0, 0, 0, 0, 0, X, X);
    step(0, "fwd_dr",  NOP,          0, 0, 0, 0, 0, X, X);

    // Load-use: one stall, then MEM/WB forward on rs2.
    step(0, "lu_lw",    lw(7, 1),     0, 0, 0, 0, 0, 0, X);
    step(0, "lu_stall", alu(8, 1, 7), 0, 0, 1, 0, 0, 0, X);
    step(0, "lu_go",    alu(8, 1, 7), 0, 0, 0, 0, 0, 1, X);
    step(0, "lu_ex",    NOP,          0, 0, 0, 0, 2, 1, X);
    repeat (3) step(0, "lu_dr", NOP,  0, 0, 0, 0, 0, X, X);

    // Producer in WB without register-file bypass forces one stall.
    step(0, "wb_add",   alu(9, 1, 2),  0, 0, 0, 0, 0, X, X);
    step(0, "wb_n1",    NOP,           0, 0, 0, 0, 0, X, X);
    step(0, "wb_n2",    NOP,           0, 0, 0, 0, 0, X, X);
    step(0, "wb_stall", alu(10, 9, 1), 0, 0, 1, 0, 0, 1, X);
    step(0, "wb_go",    alu(10, 9, 1), 0, 0, 0, 0, 0, 2, X);
    step(0, "wb_ex",    NOP,           0, 0, 0, 0, 0, 2, X);
    repeat (3) step(0, "wb_dr", NOP,   0, 0, 0, 0, 0, X, X);

    // Jump coincident with a load-use match: flush wins, EX and MEM squashed.
    step(0, "fl_lw",    lw(7, 1),     0, 0, 0, 0, 0, 2, 0);
    step(0, "fl_jmp",   alu(8, 1, 7), 1, 0, 0, 0, 0, 2, 0);
    step(0, "fl_after", alu(8, 1, 7), 0, 0, 0, 0, 0, 2, 1);
    step(0, "fl_ex",    NOP,          0, 0, 0, 0, 0, 2, 1);
    repeat (3) step(0, "fl_dr", NOP,  0, 0, 0, 0, 0, X, X);

    // x0 is never a hazard or a forward source; unused sources are ignored.
    step(0, "x0_lw",   lw(0, 1),      0, 0, 0, 0, 0, X, X);
    step(0, "x0_use",  alu(11, 0, 2), 0, 0, 0, 0, 0, X, X);
    step(0, "x0_add",  alu(0, 1, 2),  0, 0, 0, 0, 0, X, X);
    step(0, "x0_use2", alu(11, 0, 2), 0, 0, 0, 0, 0, X, X);
    step(0, "x0_ex",   NOP,           0, 0, 0, 0, 0, 2, 1);
    step(0, "un_lw",   lw(12, 1),     0, 0, 0, 0, 0, X, X);
    begin
      ins_t i;
      i = alu(13, 1, 12);
      i.u2 = 1'b0;
      step(0, "un_use", i, 0, 0, 0, 0, 0, 2, X);
    end
    step(0, "clr",     NOP,           0, 1, 0, 0, 0, X, X);
    step(0, "clr_chk", NOP,           0, 0, 0, 0, 0, 0, 0);

    // Stall-only: producer stalls the consumer through EX, MEM and WB.
    step(1, "so_add", alu(3, 1, 2), 0, 0, 0, 0, 0, 0, 0);
    step(1, "so_s1",  alu(4, 3, 2), 0, 0, 1, 0, 0, 0, X);
    step(1, "so_s2",  alu(4, 3, 2), 0, 0, 1, 0, 0, 1, X);
    step(1, "so_s3",  alu(4, 3, 2), 0, 0, 1, 0, 0, 2, X);
    step(1, "so_go",  alu(4, 3, 2), 0, 0, 0, 0, 0, 3, X);
    step(1, "so_ex",  NOP,          0, 0, 0, 0, 0, 3, X);
    repeat (3) step(1, "so_dr", NOP, 0, 0, 0, 0, 0, X, X);

    // Self-dependent instruction held: issue, 3 stalls, repeat; 18 more stalls.
    for (int k = 0; k < 24; k++)
      step(1, "sat", alu(3, 3, 2), 0, 0, (k % 4 != 0) ? 1 : 0, 0, 0, X, X);
    step(1, "sat_chk", NOP, 0, 0, 0, 0, 0, 15, 0);

    // Clear during a stall cycle beats the increment.
    step(1, "cp_add", alu(3, 1, 2), 0, 0, 0, 0, 0, 15, X);
    step(1, "cp_clr", alu(4, 3, 2), 0, 1, 1, 0, 0, 15, X);
    step(1, "cp_s2",  alu(4, 3, 2), 0, 0, 1, 0, 0, 0, X);
    step(1, "cp_s3",  alu(4, 3, 2), 0, 0, 1, 0, 0, 1, X);
    step(1, "cp_go",  alu(4, 3, 2), 0, 0, 0, 0, 0, 2, X);
    repeat (3) step(1, "cp_dr", NOP, 0, 0, 0, 0, 0, X, X);

    // Reset pulse in the middle of a stall.
    step(1, "rs_add", alu(3, 1, 2), 0, 0, 0, 0, 0, 2, X);
    step(1, "rs_s1",  alu(4, 3, 2), 0, 0, 1, 0, 0, 2, X);
    step(1, "rs_s2",  alu(4, 3, 2), 0, 0, 1, 0, 0, 3, X);
    @(negedge clk); #1;
    rst_b = 1'b1;
    step(1, "rs_in",  alu(4, 3, 2), 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    step(1, "rs_post",  alu(4, 3, 2), 0, 0, 0, 0, 0, 0, 0);
    step(1, "rs_post2", NOP,          0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter FWD_EN, default 1; 1 = forwarding with load-use interlock, 0 = stall-only interlock.
REQ-003 SHALL have parameter RF_BYPASS, default 0; 1 = register file returns same-cycle write data on read.
REQ-004 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk in 1 (rising edge), rst in 1.
REQ-006 SHALL have the following decode-stage ports, all inputs: id_valid 1; id_rs1 REG_AW; id_rs2 REG_AW; id_rs1_used 1; id_rs2_used 1; id_rd REG_AW; id_reg_write 1; id_is_load 1.
REQ-007 SHALL have jump_taken in 1, asserted when the instruction in MEM redirects the PC.
REQ-008 SHALL have cnt_clr in 1, synchronous clear of both counters.
REQ-009 SHALL have the following outputs: stall 1 (hold PC and IF/ID; combinational); flush_if_id, flush_id_ex, flush_ex_mem, each 1 and combinational.
REQ-010 SHALL have fwd_a_sel and fwd_b_sel outputs, each 2 bits and registered, applying to the instruction in EX: 0 = ID/EX operand, 1 = EX/MEM result, 2 = MEM/WB write data.
REQ-011 SHALL have stall_cnt and flush_cnt outputs, each CNT_W bits.

Function
REQ-012 SHALL track three slots: S0 = EX, S1 = MEM, S2 = WB. Each slot holds {valid, rd, wr, load}.
REQ-013 SHALL treat a slot as a producer of register r only when valid=1, wr=1, rd=r and r!=0.
REQ-014 SHALL treat a source as live only when id_valid=1, its *_used=1 and its address is nonzero.
REQ-015 With FWD_EN=1, SHALL assert stall when a live source matches an S0 producer with load=1, or matches an S2 producer while RF_BYPASS=0.
REQ-016 With FWD_EN=0, SHALL assert stall when a live source matches a producer in S0 or S1, or in S2 while RF_BYPASS=0.
REQ-017 SHALL hold stall low when id_valid=0 or jump_taken=1; flush wins over stall.
REQ-018 On jump_taken=1, SHALL assert flush_if_id, flush_id_ex and flush_ex_mem in the same cycle.
REQ-019 Each clock edge, SHALL load S2<=S1.
REQ-020 Each clock edge, SHALL load S1<=S0, or invalid when jump_taken=1.
REQ-021 Each clock edge, SHALL load S0<=decode info when id_valid=1, stall=0 and jump_taken=0; otherwise S0<=invalid (bubble).
REQ-022 At the same edge as an S0 issue, SHALL register fwd_*_sel per live source: 1 if it matches an S0 producer (non-load); else 2 if it matches an S1 producer; else 0.
REQ-023 SHALL set fwd_*_sel to 0 whenever a bubble is issued or FWD_EN=0.
REQ-024 SHALL never update fwd_*_sel while stall=1 other than to 0 with the bubble.
REQ-025 SHALL increment stall_cnt in each cycle stall=1 and flush_cnt in each cycle jump_taken=1; both counters saturate at all-ones.
REQ-026 cnt_clr SHALL zero both counters and take priority over increment in that cycle.
REQ-027 SHALL stall for at most one cycle per load-use hazard (FWD_EN=1); with FWD_EN=0 the stall SHALL persist until no match remains.

Reset
REQ-028 While rst=1, SHALL force all slots invalid, fwd_a_sel=fwd_b_sel=0 and stall_cnt=flush_cnt=0; combinational outputs SHALL then evaluate low.
REQ-029 Reset asserted mid-stall or mid-flush SHALL abort the event immediately, with no residual stall after release.

Structure
REQ-030 SHALL place the fwd select encodings (FWD_ID=0, FWD_EXMEM=1, FWD_MEMWB=2) and the slot record type in shared package pipe_pkg.
REQ-031 SHALL implement the slot shift register with flush/bubble insertion as sub-module pipe_scoreboard; hazard compare, forward select and counters SHALL reside in hazard_ctrl.

Verification
REQ-032 Bench SHALL cover forwarding: FWD_EN=1, ADD x5 issued, then SUB using rs1=x5 next cycle -> stall=0; fwd_a_sel=1 in SUB's EX cycle.
REQ-033 Bench SHALL cover load-use: LW x7 then ADD rs2=x7 -> stall=1 for exactly one cycle, S0 bubble, then fwd_b_sel=2; stall_cnt=1.
REQ-034 Bench SHALL cover stall-only mode: FWD_EN=0, RF_BYPASS=0, ADD x3 then consumer of x3 -> stall high 3 cycles; fwd sels remain 0.
REQ-035 Bench SHALL cover flush priority: jump_taken=1 coincident with a load-use match -> stall=0, all three flushes=1, next cycle S0 and S1 invalid; flush_cnt=1.
REQ-036 Bench SHALL cover x0 and counters: rd=x0 producer followed by rs1=x0 consumer -> no stall, fwd_a_sel=0. With CNT_W=4, 20 stall cycles -> stall_cnt=15; cnt_clr -> 0.
REQ-037 Bench SHALL cover reset: rst pulse during a FWD_EN=0 stall -> stall low after release, counters 0, fwd sels 0.
